ka_operand_split_seq_25bit: RTL and testbench

// - Splits one 25-bit GF(2) operand pair into the three Karatsuba sub-operand pairs.
// - Issues the pairs one beat at a time to a shared 13-bit carry-less sub-multiplier.
// - Order: low, middle, high. The sub-multiplier results feed the 25-bit overlap recombiner.
// - Sits in the KA_193bit tree at the 25-bit level, upstream of the sub-multiplier.

---
 rtl/ka_split_pkg.sv | 48 ++++
 rtl/ka_split_comb_25bit.sv | 38 +++
 rtl/ka_operand_split_seq_25bit.sv | 120 ++++++++++++
 tb/tb_ka_operand_split_seq_25bit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ka_split_pkg.sv
// Shared constants, tag codes, FSM encoding and operand-split helper for the
// Karatsuba operand splitter family.
package ka_split_pkg;

  localparam int N    = 25;
  localparam int LO_W = (N + 1) / 2;
  localparam int HI_W = N - LO_W;

  localparam logic [1:0] TAG_LO  = 2'd0;
  localparam logic [1:0] TAG_MID = 2'd1;
  localparam logic [1:0] TAG_HI  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_MID  = 2'd2,
    ST_HI   = 2'd3
  } state_t;

  typedef struct packed {
    logic [LO_W-1:0] a0;
    logic [LO_W-1:0] a1;
    logic [LO_W-1:0] b0;
    logic [LO_W-1:0] b1;
  } operands_t;

  // High halves are zero-extended so all three sub-operands share one width.
  function automatic operands_t split_operands(input logic [N-1:0] a,
                                               input logic [N-1:0] b);
    operands_t o;
    o.a0 = a[LO_W-1:0];
    o.a1 = {{(LO_W-HI_W){1'b0}}, a[N-1:LO_W]};
    o.b0 = b[LO_W-1:0];
    o.b1 = {{(LO_W-HI_W){1'b0}}, b[N-1:LO_W]};
    return o;
  endfunction

  function automatic logic [1:0] state_tag(input state_t s);
    logic [1:0] t;
    case (s)
      ST_MID:  t = TAG_MID;
      ST_HI:   t = TAG_HI;
      default: t = TAG_LO;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ka_split_comb_25bit.sv
// Purely combinational Karatsuba beat selector: maps the split operand halves
// and a beat tag onto one sub-operand pair (GF(2), XOR only).
module ka_split_comb_25bit
  import ka_split_pkg::*;
(
  input  logic [LO_W-1:0] a0_i,
  input  logic [LO_W-1:0] a1_i,
  input  logic [LO_W-1:0] b0_i,
  input  logic [LO_W-1:0] b1_i,
  input  logic [1:0]      tag_i,
  output logic [LO_W-1:0] sub_a_o,
  output logic [LO_W-1:0] sub_b_o
);

  always_comb begin
    sub_a_o = '0;
    sub_b_o = '0;
    case (tag_i)
      TAG_LO: begin
        sub_a_o = a0_i;
        sub_b_o = b0_i;
      end
      TAG_MID: begin
        sub_a_o = a0_i ^ a1_i;
        sub_b_o = b0_i ^ b1_i;
      end
      TAG_HI: begin
        sub_a_o = a1_i;
        sub_b_o = b1_i;
      end
      default: begin
        sub_a_o = '0;
        sub_b_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/ka_operand_split_seq_25bit.sv
// Sequential 25-bit Karatsuba operand splitter: one accepted operand pair is
// issued as LO, MID, HI beats to a shared 13-bit sub-multiplier.
// Optional macro KA_SPLIT_PERF_EN adds the op_count completed-pair counter.
//
// Handshakes: a transfer happens on a rising edge where valid && ready; valid
// never waits on ready, and in_ready never depends on in_valid.
module ka_operand_split_seq_25bit
  import ka_split_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LO_W-1:0] out_a,
  output logic [LO_W-1:0] out_b,
  output logic [1:0]      out_tag,
  output logic            out_last,
  output logic            busy
`ifdef KA_SPLIT_PERF_EN
  ,
  output logic [15:0]     op_count
`endif
);

  state_t          state_q, state_d;
  operands_t       ops_q, ops_d;
  logic            accept, beat_done;
  logic [1:0]      tag_d;
  logic [LO_W-1:0] beat_a, beat_b;
  logic [LO_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic [1:0]      out_tag_q, out_tag_d;
  logic            out_last_q, out_last_d;

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_HI) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q != ST_IDLE);
  assign beat_done = out_valid & out_ready;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_LO;
      ST_LO:   if (beat_done) state_d = ST_MID;
      ST_MID:  if (beat_done) state_d = ST_HI;
      ST_HI:   if (beat_done) state_d = accept ? ST_LO : ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  assign ops_d = accept ? split_operands(in_a, in_b) : ops_q;
  assign tag_d = state_tag(state_d);

  // The beat registers are fed from next-state values, so the beat is ready
  // the cycle after the transition and recomputes identically while stalled.
  ka_split_comb_25bit u_comb (
    .a0_i    (ops_d.a0),
    .a1_i    (ops_d.a1),
    .b0_i    (ops_d.b0),
    .b1_i    (ops_d.b1),
    .tag_i   (tag_d),
    .sub_a_o (beat_a),
    .sub_b_o (beat_b)
  );

  always_comb begin
    out_a_d    = '0;
    out_b_d    = '0;
    out_tag_d  = TAG_LO;
    out_last_d = 1'b0;
    if (state_d != ST_IDLE) begin
      out_a_d    = beat_a;
      out_b_d    = beat_b;
      out_tag_d  = tag_d;
      out_last_d = (state_d == ST_HI);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ops_q      <= '0;
      out_a_q    <= '0;
      out_b_q    <= '0;
      out_tag_q  <= TAG_LO;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ops_q      <= ops_d;
      out_a_q    <= out_a_d;
      out_b_q    <= out_b_d;
      out_tag_q  <= out_tag_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_a    = out_a_q;
  assign out_b    = out_b_q;
  assign out_tag  = out_tag_q;
  assign out_last = out_last_q;

`ifdef KA_SPLIT_PERF_EN
  logic [15:0] op_count_q, op_count_d;

  // Counts completed pairs; natural 16-bit wrap.
  assign op_count_d = ((state_q == ST_HI) && beat_done) ? op_count_q + 16'd1 : op_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_count_q <= '0;
    else     op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_ka_operand_split_seq_25bit.sv
// Directed testbench for ka_operand_split_seq_25bit (define KA_SPLIT_PERF_EN
// to also exercise op_count).
module tb_ka_operand_split_seq_25bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_a, out_b;
  logic [1:0]  out_tag;
  logic        out_last;
  logic        busy;
`ifdef KA_SPLIT_PERF_EN
  logic [15:0] op_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [28:0] exp_q[$];

  always #5 clk = ~clk;

  ka_operand_split_seq_25bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_tag   (out_tag),
    .out_last  (out_last),
    .busy      (busy)
`ifdef KA_SPLIT_PERF_EN
    ,
    .op_count  (op_count)
`endif
  );

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, out_tag, out_last, out_a, out_b, busy} !== 31'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0",
               {out_valid, out_tag, out_last, out_a, out_b, busy});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      bad++;
      $display("FAIL reset_release got=%b exp=100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_pair(input logic [24:0] a, input logic [24:0] b,
                           input logic [12:0] ea0, input logic [12:0] ea1,
                           input logic [12:0] ea2, input logic [12:0] eb0,
                           input logic [12:0] eb1, input logic [12:0] eb2,
                           input string nm);
    logic [12:0] ea [3];
    logic [12:0] eb [3];
    logic [29:0] exp_beat;
    ea[0] = ea0; ea[1] = ea1; ea[2] = ea2;
    eb[0] = eb0; eb[1] = eb1; eb[2] = eb2;
    @(negedge clk);
    out_ready = 1'b1;
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      exp_beat = {1'b1, 2'(k), (k == 2), ea[k], eb[k]};
      total++;
      if ({out_valid, out_tag, out_last, out_a, out_b} !== exp_beat) begin
        bad++;
        $display("FAIL %s_beat%0d got=%h exp=%h", nm, k,
                 {out_valid, out_tag, out_last, out_a, out_b}, exp_beat);
      end
      total++;
      if (in_ready !== (k == 2)) begin
        bad++;
        $display("FAIL %s_in_ready%0d got=%b exp=%b", nm, k, in_ready, (k == 2));
      end
    end
    @(negedge clk);
    total++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      bad++;
      $display("FAIL %s_idle got=%b exp=001", nm, {out_valid, busy, in_ready});
    end
  endtask

  task automatic test_backpressure();
    logic [29:0] mid_beat;
    mid_beat = {1'b1, 2'd1, 1'b0, 13'h0001, 13'h0006};
    @(negedge clk);
    out_ready = 1'b1;
    in_a = 25'h0004003; in_b = 25'h0006005; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_tag, out_last, out_a, out_b} !== {1'b1, 2'd0, 1'b0, 13'h0003, 13'h0005}) begin
      bad++;
      $display("FAIL bp_lo got=%h exp=%h", {out_valid, out_tag, out_last, out_a, out_b},
               {1'b1, 2'd0, 1'b0, 13'h0003, 13'h0005});
    end
    @(negedge clk);
    total++;
    if ({out_valid, out_tag, out_last, out_a, out_b} !== mid_beat) begin
      bad++;
      $display("FAIL bp_mid got=%h exp=%h", {out_valid, out_tag, out_last, out_a, out_b}, mid_beat);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 25'h1555555; in_b = 25'h0AAAAAA;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_tag, out_last, out_a, out_b} !== mid_beat) begin
        bad++;
        $display("FAIL bp_hold%0d got=%h exp=%h", c,
                 {out_valid, out_tag, out_last, out_a, out_b}, mid_beat);
      end
      total++;
      if ({in_ready, busy} !== 2'b01) begin
        bad++;
        $display("FAIL bp_ready%0d got=%b exp=01", c, {in_ready, busy});
      end
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, out_tag, out_last, out_a, out_b} !== {1'b1, 2'd2, 1'b1, 13'h0002, 13'h0003}) begin
      bad++;
      $display("FAIL bp_hi got=%h exp=%h", {out_valid, out_tag, out_last, out_a, out_b},
               {1'b1, 2'd2, 1'b1, 13'h0002, 13'h0003});
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_idle got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [28:0] exp_beat;
    exp_q.push_back({2'd0, 1'b0, 13'h1FFF, 13'h0001});
    exp_q.push_back({2'd1, 1'b0, 13'h1000, 13'h0001});
    exp_q.push_back({2'd2, 1'b1, 13'h0FFF, 13'h0000});
    exp_q.push_back({2'd0, 1'b0, 13'h0000, 13'h1000});
    exp_q.push_back({2'd1, 1'b0, 13'h0800, 13'h1000});
    exp_q.push_back({2'd2, 1'b1, 13'h0800, 13'h0000});
    @(negedge clk);
    out_ready = 1'b1;
    in_a = 25'h1FFFFFF; in_b = 25'h0000001; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_beat = exp_q.pop_front();
      total++;
      if ({out_valid, out_tag, out_last, out_a, out_b} !== {1'b1, exp_beat}) begin
        bad++;
        $display("FAIL b2b_beat%0d got=%h exp=%h", k,
                 {out_valid, out_tag, out_last, out_a, out_b}, {1'b1, exp_beat});
      end
      if (k == 0) begin
        in_a = 25'h1000000; in_b = 25'h0001000;
      end
      if (k == 3) in_valid = 1'b0;
    end
    @(negedge clk);
    total++;
    if ({out_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_idle got=%b exp=00", {out_valid, busy});
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b1;
    in_a = 25'h1FFFFFF; in_b = 25'h0000001; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, out_tag} !== 3'b101) begin
      bad++;
      $display("FAIL rstmid_at_mid got=%b exp=101", {out_valid, out_tag});
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({out_valid, out_tag, out_last, out_a, out_b, busy, in_ready} !== 32'd1) begin
      bad++;
      $display("FAIL rstmid_outputs got=%h exp=1",
               {out_valid, out_tag, out_last, out_a, out_b, busy, in_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
        bad++;
        $display("FAIL rstmid_after%0d got=%b exp=100", c, {in_ready, out_valid, busy});
      end
    end
  endtask

`ifdef KA_SPLIT_PERF_EN
  task automatic drive_pair(input logic [24:0] a, input logic [24:0] b);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 10) begin
      bad++;
      $display("FAIL perf_drain_timeout got=%0d exp=<10", n);
    end
  endtask

  task automatic test_perf();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (op_count !== 16'd0) begin
      bad++;
      $display("FAIL perf_reset got=%h exp=0", op_count);
    end
    drive_pair(25'h1FFFFFF, 25'h0000001);
    drive_pair(25'h1000000, 25'h0001000);
    drive_pair(25'h0004003, 25'h0006005);
    total++;
    if (op_count !== 16'd3) begin
      bad++;
      $display("FAIL perf_three got=%h exp=3", op_count);
    end
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    drive_pair(25'h0000003, 25'h0000005);
    total++;
    if (op_count !== 16'd0) begin
      bad++;
      $display("FAIL perf_wrap got=%h exp=0", op_count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    test_reset();
    test_pair(25'h1FFFFFF, 25'h0000001,
              13'h1FFF, 13'h1000, 13'h0FFF, 13'h0001, 13'h0001, 13'h0000, "single");
    test_pair(25'h1000000, 25'h0001000,
              13'h0000, 13'h0800, 13'h0800, 13'h1000, 13'h1000, 13'h0000, "msb");
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef KA_SPLIT_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
